// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         MD_CNT_W = 8;

    // A load into $zero never creates a real dependency, so it is excluded.
    function automatic logic is_load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rs,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - HI/LO occupancy timer for multiply/divide
// Ports: clk, rst_n (async active-low), md_start (load MD_LAT), md_busy (count non-zero).
module md_busy_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LAT);

    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    // A new mult/div restarts the window even while a previous one is in flight.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = LAT;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - front-of-pipeline stall/flush/halt sequencer with perf counters
// Ports: hazard inputs from ID/EX (id_*, ex_*, md_start), go resumes from halt;
//        outputs pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, halted,
//        saturating stall_cnt / flush_cnt.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reads_hilo,
    input  logic             id_syscall,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             md_start,
    input  logic             go,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t            state_q, state_d;
    logic              resume_q, resume_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic              stall;

    md_busy_timer #(.MD_LAT(MD_LAT)) u_md_busy_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    assign load_use = is_load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign stall    = load_use || (id_reads_hilo && md_busy);

    // resume_q marks the first RUN cycle after a halt: the syscall still sitting in
    // IF/ID must be flushed rather than re-executed. If a hazard stalls that cycle,
    // the flush is deferred until the stall clears.
    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (state_q)
            ST_HALT: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (go) begin
                    state_d  = ST_RUN;
                    resume_d = 1'b1;
                end
            end
            default: begin
                if (stall) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (resume_q) begin
                    if_id_flush = 1'b1;
                    resume_d    = 1'b0;
                end else if (id_syscall) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    state_d  = ST_HALT;
                end else if (id_branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end
        endcase
    end

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            resume_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_uses_rs = 0, id_uses_rt = 0, id_reads_hilo = 0, id_syscall = 0;
    logic id_branch_taken = 0, ex_mem_read = 0, md_start = 0, go = 0;

    logic pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_flush_s, md_busy_s, halted_s;
    logic [3:0] stall_cnt_s, flush_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
        .id_syscall(id_syscall), .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .md_start(md_start), .go(go), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.MD_LAT(LAT), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
        .id_syscall(id_syscall), .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .md_start(md_start), .go(go), .pc_en(pc_en_s), .if_id_en(if_id_en_s),
        .if_id_flush(if_id_flush_s), .id_ex_flush(id_ex_flush_s), .md_busy(md_busy_s),
        .halted(halted_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: halted flag, "owe a flush after halt" flag,
    // remaining mult/div cycles, and plain integer counters.
    bit     m_halted, m_owe_flush;
    int     m_md_left;
    longint m_stalls, m_flushes;

    always @(negedge clk) begin
        bit lu, busy, hz;
        bit e_pc, e_ifen, e_iff, e_idf;
        if (!rst_n) begin
            m_halted = 0; m_owe_flush = 0; m_md_left = 0; m_stalls = 0; m_flushes = 0;
        end
        lu = ex_mem_read && ex_rt != 0 &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        busy = m_md_left > 0;
        hz = lu || (id_reads_hilo && busy);
        if (m_halted)              {e_pc, e_ifen, e_iff, e_idf} = 4'b0001;
        else if (hz)               {e_pc, e_ifen, e_iff, e_idf} = 4'b0001;
        else if (m_owe_flush)      {e_pc, e_ifen, e_iff, e_idf} = 4'b1110;
        else if (id_syscall)       {e_pc, e_ifen, e_iff, e_idf} = 4'b0000;
        else if (id_branch_taken)  {e_pc, e_ifen, e_iff, e_idf} = 4'b1110;
        else                       {e_pc, e_ifen, e_iff, e_idf} = 4'b1100;

        check("pc_en", pc_en, e_pc);
        check("if_id_en", if_id_en, e_ifen);
        check("if_id_flush", if_id_flush, e_iff);
        check("id_ex_flush", id_ex_flush, e_idf);
        check("md_busy", md_busy, busy);
        check("halted", halted, m_halted);
        check("stall_cnt", stall_cnt, m_stalls);
        check("flush_cnt", flush_cnt, m_flushes);
        check("stall_cnt_w4", stall_cnt_s, (m_stalls > 15) ? 15 : m_stalls);
        check("flush_cnt_w4", flush_cnt_s, (m_flushes > 15) ? 15 : m_flushes);

        if (rst_n) begin
            if (!e_pc) m_stalls++;
            if (e_iff) m_flushes++;
            m_md_left = md_start ? LAT : (busy ? m_md_left - 1 : 0);
            if (m_halted) begin
                if (go) begin m_halted = 0; m_owe_flush = 1; end
            end else if (!hz) begin
                if (m_owe_flush) m_owe_flush = 0;
                else if (id_syscall) m_halted = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        {id_uses_rs, id_uses_rt, id_reads_hilo, id_syscall, id_branch_taken, ex_mem_read, md_start, go} = '0;
        id_rs = 0; id_rt = 0; ex_rt = 0;
    endtask

    initial begin
        quiet();
        rst_n = 0;
        repeat (2) step();
        #1;
        check("rst pc_en", pc_en, 1);
        check("rst if_id_en", if_id_en, 1);
        check("rst md_busy", md_busy, 0);
        check("rst stall_cnt", stall_cnt, 0);
        rst_n = 1;
        step();

        // load-use on rs
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
        #1;
        check("lu pc_en", pc_en, 0);
        check("lu id_ex_flush", id_ex_flush, 1);
        step();
        quiet();
        #1;
        check("lu stall_cnt", stall_cnt, 1);
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        check("lu r0 pc_en", pc_en, 1);
        step();
        quiet();

        // HI/LO busy window
        md_start = 1;
        step();
        md_start = 0; id_reads_hilo = 1;
        for (int i = 0; i < LAT; i++) begin
            #1;
            check("hilo stall pc_en", pc_en, 0);
            step();
        end
        #1;
        check("hilo release pc_en", pc_en, 1);
        step();
        quiet();

        // branch loses to stall, then flushes
        id_branch_taken = 1; ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1;
        #1;
        check("br+lu if_id_flush", if_id_flush, 0);
        step();
        ex_mem_read = 0;
        #1;
        check("br if_id_flush", if_id_flush, 1);
        check("br pc_en", pc_en, 1);
        step();
        quiet();

        // syscall halt and resume
        id_syscall = 1;
        step();
        #1;
        check("halt halted", halted, 1);
        check("halt id_ex_flush", id_ex_flush, 1);
        step();
        go = 1;
        step();
        go = 0;
        #1;
        check("exit halted", halted, 0);
        check("exit if_id_flush", if_id_flush, 1);
        check("exit pc_en", pc_en, 1);
        step();
        quiet();

        // async reset mid mult/div
        md_start = 1;
        step();
        md_start = 0;
        #2;
        rst_n = 0;
        #1;
        check("async md_busy", md_busy, 0);
        check("async stall_cnt", stall_cnt, 0);
        check("async pc_en", pc_en, 1);
        step();
        rst_n = 1;
        step();

        // saturation of the 4-bit counter
        ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
        repeat (20) step();
        quiet();
        #1;
        check("sat stall_cnt_w4", stall_cnt_s, 15);
        check("sat stall_cnt", stall_cnt, 20);
        step();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            ex_mem_read     = ($urandom_range(2) == 0);
            ex_rt           = 5'($urandom_range(3));
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            id_uses_rs      = $urandom_range(1);
            id_uses_rt      = $urandom_range(1);
            id_reads_hilo   = ($urandom_range(2) == 0);
            md_start        = ($urandom_range(15) == 0);
            id_syscall      = ($urandom_range(19) == 0);
            id_branch_taken = ($urandom_range(3) == 0);
            go              = ($urandom_range(3) == 0);
            rst_n           = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1;
        quiet();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
